eth_tx_app_buf: RTL and testbench

- Store-and-forward adapter sitting directly upstream of eth_tx, on its application-side TX interface.
- Accepts a packet as a simple valid/ready byte stream and buffers the whole packet, so its length is known before transmission.
- Then runs the eth_tx head handshake (early_v / ready_v) and streams the packet gap-free with the last-block look-ahead signals eth_tx requires.
- Holds one packet at a time.

---
 rtl/eth_tx_app_buf.sv | 232 +++++++++++++++++++++++
 tb/tb_eth_tx_app_buf.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_app_buf.sv
// eth_tx_app_buf: store-and-forward adapter in front of eth_tx.
// Buffers one whole packet from a valid/ready byte stream, then runs the
// eth_tx head handshake and replays the packet gap-free, with the
// last-PCS-block look-ahead signals.
//
// Ports
//   clk, nreset                 clock, async active-low reset
//   s_valid_i/s_ready_o         input beat handshake
//   s_data_i/s_keep_i/s_last_i  input beat payload, byte 0 in bits [7:0]
//   s_cancel_i                  discard the packet being filled
//   app_early_v_o/app_ready_v_i head request / grant with eth_tx
//   app_pkt_len_o               buffered byte count, held until back in idle
//   app_data_o/app_len_o        output word and byte keep mask
//   app_last_o                  final output beat
//   app_last_block_next_o       next PCS block is the last one
//   app_last_block_next_len_o   byte count of that last block
//   app_cancel_o/app_cs_o       constant 0
//   drop_o                      one-cycle pulse when a packet is discarded
module eth_tx_app_buf #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BLOCK_N        = 8,
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned MAX_PKT_LEN    = 1472,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [DATA_W-1:0]         s_data_i,
  input  logic [KEEP_W-1:0]         s_keep_i,
  input  logic                      s_last_i,
  input  logic                      s_cancel_i,
  output logic                      app_early_v_o,
  input  logic                      app_ready_v_i,
  output logic [PKT_LEN_W-1:0]      app_pkt_len_o,
  output logic [DATA_W-1:0]         app_data_o,
  output logic [KEEP_W-1:0]         app_len_o,
  output logic                      app_last_o,
  output logic                      app_last_block_next_o,
  output logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_o,
  output logic                      app_cancel_o,
  output logic [15:0]               app_cs_o,
  output logic                      drop_o
);

  localparam int unsigned DEPTH = MAX_PKT_LEN / KEEP_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(KEEP_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_REQ, ST_SEND} state_e;

  state_e                    state_q;
  logic                      s_ready_q;
  logic                      ovf_q;
  logic                      drop_q;
  logic                      early_v_q;
  logic [PKT_LEN_W-1:0]      len_q;
  logic [PKT_LEN_W-1:0]      pkt_len_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [DATA_W-1:0]         data_q;
  logic [KEEP_W-1:0]         keep_q;
  logic                      last_q;
  logic                      lbn_q;
  logic [APP_LAST_LEN_W-1:0] lbn_len_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Input side: byte count of the beat and the overflow decision
  logic                 beat_acc;
  logic [CNT_W-1:0]     pop_cnt;
  logic [PKT_LEN_W-1:0] len_sum;
  logic                 too_big;
  logic                 wr_en;

  always_comb begin
    pop_cnt = '0;
    for (int unsigned k = 0; k < KEEP_W; k++) begin
      pop_cnt = pop_cnt + CNT_W'(s_keep_i[k]);
    end
  end

  assign beat_acc = s_valid_i & s_ready_q;
  assign len_sum  = len_q + PKT_LEN_W'(pop_cnt);
  // Once oversized the packet stays flagged; len_q is frozen from then on
  assign too_big  = ovf_q | (len_sum > PKT_LEN_W'(MAX_PKT_LEN));
  assign wr_en    = beat_acc & ~s_cancel_i & ~too_big;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s_data_i;
    end
  end

  // Output side: content of beat rd_ptr_q, loaded into the output registers
  logic [PKT_LEN_W-1:0]      full_beats;
  logic [PKT_LEN_W-1:0]      rem_bytes;
  logic [PKT_LEN_W-1:0]      rd_byte;
  logic                      beat_final;
  logic [KEEP_W-1:0]         beat_keep;
  logic [DATA_W-1:0]         beat_data;
  logic [DATA_W-1:0]         rd_word;
  logic                      beat_lbn;
  logic [APP_LAST_LEN_W-1:0] beat_lbn_len;

  always_comb begin
    full_beats = len_q / PKT_LEN_W'(KEEP_W);
    rem_bytes  = len_q % PKT_LEN_W'(KEEP_W);
    rd_byte    = PKT_LEN_W'(rd_ptr_q) * PKT_LEN_W'(KEEP_W);
    beat_final = (PKT_LEN_W'(rd_ptr_q) == full_beats);
    rd_word    = mem[rd_ptr_q];
    beat_keep  = '0;
    beat_data  = '0;
    for (int unsigned k = 0; k < KEEP_W; k++) begin
      beat_keep[k] = beat_final ? (PKT_LEN_W'(k) < rem_bytes) : 1'b1;
      beat_data[8*k +: 8] = beat_keep[k] ? rd_word[8*k +: 8] : 8'h00;
    end
    // A full beat that starts the packet's final PCS block
    beat_lbn = ~beat_final
             & ((rd_byte % PKT_LEN_W'(BLOCK_N)) == '0)
             & ((rd_byte / PKT_LEN_W'(BLOCK_N)) == (len_q / PKT_LEN_W'(BLOCK_N)));
    beat_lbn_len = beat_lbn ? APP_LAST_LEN_W'(len_q % PKT_LEN_W'(BLOCK_N)) : '0;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b1;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      early_v_q <= 1'b0;
      len_q     <= '0;
      pkt_len_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      lbn_q     <= 1'b0;
      lbn_len_q <= '0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_FILL: begin
          if (s_cancel_i && (beat_acc || state_q == ST_FILL)) begin
            // Cancel beats a simultaneous last beat
            drop_q   <= 1'b1;
            state_q  <= ST_IDLE;
            len_q    <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
          end else if (beat_acc) begin
            if (s_last_i) begin
              if (too_big || len_sum == '0) begin
                drop_q   <= 1'b1;
                state_q  <= ST_IDLE;
                len_q    <= '0;
                wr_ptr_q <= '0;
                ovf_q    <= 1'b0;
              end else begin
                state_q   <= ST_REQ;
                s_ready_q <= 1'b0;
                early_v_q <= 1'b1;
                len_q     <= len_sum;
                pkt_len_q <= len_sum;
              end
            end else begin
              state_q <= ST_FILL;
              ovf_q   <= too_big;
              if (!too_big) begin
                len_q    <= len_sum;
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
              end
            end
          end
        end
        ST_REQ: begin
          if (app_ready_v_i) begin
            early_v_q <= 1'b0;
            state_q   <= ST_SEND;
            data_q    <= beat_data;
            keep_q    <= beat_keep;
            last_q    <= beat_final;
            lbn_q     <= beat_lbn;
            lbn_len_q <= beat_lbn_len;
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
          end
        end
        ST_SEND: begin
          if (last_q) begin
            // Final beat has been presented for one cycle; back to idle
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b1;
            len_q     <= '0;
            pkt_len_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            lbn_q     <= 1'b0;
            lbn_len_q <= '0;
          end else begin
            data_q    <= beat_data;
            keep_q    <= beat_keep;
            last_q    <= beat_final;
            lbn_q     <= beat_lbn;
            lbn_len_q <= beat_lbn_len;
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready_o                 = s_ready_q;
  assign app_early_v_o             = early_v_q;
  assign app_pkt_len_o             = pkt_len_q;
  assign app_data_o                = data_q;
  assign app_len_o                 = keep_q;
  assign app_last_o                = last_q;
  assign app_last_block_next_o     = lbn_q;
  assign app_last_block_next_len_o = lbn_len_q;
  assign app_cancel_o              = 1'b0;
  assign app_cs_o                  = 16'h0000;
  assign drop_o                    = drop_q;

endmodule

// File: tb/tb_eth_tx_app_buf.sv
// Self-checking bench for eth_tx_app_buf: drivers push expected outcomes
// and output beats into queues; a monitor pops and compares.
module tb_eth_tx_app_buf;

  localparam int DATA_W      = 16;
  localparam int KEEP_W      = 2;
  localparam int BLOCK_N     = 8;
  localparam int MAX_PKT_LEN = 1472;
  localparam int LL_W        = 4;

  logic              clk = 1'b0;
  logic              nreset;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic [KEEP_W-1:0] s_keep_i;
  logic              s_last_i;
  logic              s_cancel_i;
  logic              app_early_v_o;
  logic              app_ready_v_i;
  logic [15:0]       app_pkt_len_o;
  logic [DATA_W-1:0] app_data_o;
  logic [KEEP_W-1:0] app_len_o;
  logic              app_last_o;
  logic              app_last_block_next_o;
  logic [LL_W-1:0]   app_last_block_next_len_o;
  logic              app_cancel_o;
  logic [15:0]       app_cs_o;
  logic              drop_o;

  always #5 clk = ~clk;

  eth_tx_app_buf dut (
    .clk                       (clk),
    .nreset                    (nreset),
    .s_valid_i                 (s_valid_i),
    .s_ready_o                 (s_ready_o),
    .s_data_i                  (s_data_i),
    .s_keep_i                  (s_keep_i),
    .s_last_i                  (s_last_i),
    .s_cancel_i                (s_cancel_i),
    .app_early_v_o             (app_early_v_o),
    .app_ready_v_i             (app_ready_v_i),
    .app_pkt_len_o             (app_pkt_len_o),
    .app_data_o                (app_data_o),
    .app_len_o                 (app_len_o),
    .app_last_o                (app_last_o),
    .app_last_block_next_o     (app_last_block_next_o),
    .app_last_block_next_len_o (app_last_block_next_len_o),
    .app_cancel_o              (app_cancel_o),
    .app_cs_o                  (app_cs_o),
    .drop_o                    (drop_o)
  );

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] len;
    logic              last;
    logic              lbn;
    logic [LL_W-1:0]   lbn_len;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_out[$];   // -1: packet must be dropped, else expected length
  int    errors = 0;
  int    checks = 0;
  int    req_wait = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t mk_pkt(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference model: outcome and output beats derived from the byte list
  task automatic model_pkt(input bq_t b, input bit cancelled);
    int n;
    int rem;
    int last_blk_start;
    beat_t e;
    n = b.size();
    if (cancelled || n == 0 || n > MAX_PKT_LEN) begin
      exp_out.push_back(-1);
      return;
    end
    exp_out.push_back(n);
    last_blk_start = (n / BLOCK_N) * BLOCK_N;
    for (int i = 0; i < n / KEEP_W; i++) begin
      for (int k = 0; k < KEEP_W; k++) e.data[8*k +: 8] = b[i*KEEP_W + k];
      e.len     = '1;
      e.last    = 1'b0;
      e.lbn     = (i * KEEP_W == last_blk_start);
      e.lbn_len = e.lbn ? LL_W'(n % BLOCK_N) : '0;
      exp_beats.push_back(e);
    end
    rem = n % KEEP_W;
    e.data = '0;
    e.len  = '0;
    for (int k = 0; k < rem; k++) begin
      e.data[8*k +: 8] = b[(n / KEEP_W) * KEEP_W + k];
      e.len[k] = 1'b1;
    end
    e.last    = 1'b1;
    e.lbn     = 1'b0;
    e.lbn_len = '0;
    exp_beats.push_back(e);
  endtask

  // Drive one packet; cancel_at >= 0 raises s_cancel_i on that beat and stops
  task automatic send_pkt(input bq_t b, input bit empty_last, input int cancel_at);
    int  n;
    int  nb;
    int  idx;
    int  timeout;
    bit  acc;
    bit  will_drop;
    n = b.size();
    if (empty_last) nb = n / KEEP_W + 1;
    else nb = (n == 0) ? 1 : (n + KEEP_W - 1) / KEEP_W;
    will_drop = (cancel_at >= 0) || n == 0 || n > MAX_PKT_LEN;
    model_pkt(b, cancel_at >= 0);
    for (int j = 0; j < nb; j++) begin
      if ($urandom_range(3) == 0) begin
        s_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      s_valid_i  = 1'b1;
      s_last_i   = (j == nb - 1);
      s_cancel_i = (j == cancel_at);
      s_data_i   = DATA_W'($urandom);
      s_keep_i   = '0;
      for (int k = 0; k < KEEP_W; k++) begin
        idx = j * KEEP_W + k;
        if (idx < n) begin
          s_data_i[8*k +: 8] = b[idx];
          s_keep_i[k] = 1'b1;
        end
      end
      timeout = 0;
      forever begin
        @(negedge clk);
        acc = s_ready_o;
        @(posedge clk); #1;
        if (acc) break;
        timeout++;
        if (timeout > 4000) break;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL input_accept_timeout: beat %0d never accepted", j);
        break;
      end
      if (j == cancel_at || j == nb - 1) begin
        if (will_drop) check("drop_latency", drop_o, 1);
        else check("early_latency", app_early_v_o, 1);
        break;
      end
    end
    s_valid_i  = 1'b0;
    s_last_i   = 1'b0;
    s_cancel_i = 1'b0;
    s_keep_i   = '0;
    s_data_i   = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_out.size() != 0 || exp_beats.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (t >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: %0d outcomes and %0d beats still pending", exp_out.size(), exp_beats.size());
      exp_out.delete();
      exp_beats.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // eth_tx side: grant the head request req_wait cycles after it appears
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    app_ready_v_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (app_early_v_o) begin
        if (wait_cnt >= req_wait) app_ready_v_i = 1'b1;
        else begin
          app_ready_v_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        app_ready_v_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: beats start in the cycle the head request drops
  initial begin
    bit    prev_early;
    bit    in_beats;
    bit    chk_rdy;
    int    o;
    int    cur_len;
    beat_t e;
    prev_early = 1'b0;
    in_beats   = 1'b0;
    chk_rdy    = 1'b0;
    cur_len    = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_early = 1'b0;
        in_beats   = 1'b0;
        chk_rdy    = 1'b0;
        continue;
      end
      if (chk_rdy) begin
        check("s_ready_after_pkt", s_ready_o, 1);
        chk_rdy = 1'b0;
      end
      if (drop_o) begin
        if (exp_out.size() == 0) check("unexpected_drop", drop_o, 0);
        else begin
          o = exp_out.pop_front();
          check("outcome_on_drop", 32'hFFFF_FFFF, o);
        end
      end
      if (app_early_v_o && !prev_early) begin
        if (exp_out.size() == 0) check("unexpected_early_v", app_early_v_o, 0);
        else begin
          o = exp_out.pop_front();
          check("early_pkt_len", 32'(app_pkt_len_o), o);
        end
        cur_len = app_pkt_len_o;
      end
      if (app_early_v_o) begin
        check("req_len_stable", 32'(app_pkt_len_o), cur_len);
        check("req_s_ready_low", s_ready_o, 0);
      end
      if (prev_early && !app_early_v_o) in_beats = 1'b1;
      if (in_beats) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 1, 0);
          in_beats = 1'b0;
        end else begin
          e = exp_beats.pop_front();
          check("beat_data", 32'(app_data_o), 32'(e.data));
          check("beat_len", 32'(app_len_o), 32'(e.len));
          check("beat_last", app_last_o, e.last);
          check("beat_lbn", app_last_block_next_o, e.lbn);
          check("beat_lbn_len", 32'(app_last_block_next_len_o), 32'(e.lbn_len));
          check("send_s_ready_low", s_ready_o, 0);
          if (e.last) begin
            in_beats = 1'b0;
            chk_rdy  = 1'b1;
          end
        end
      end else if (!app_early_v_o) begin
        check("idle_last_low", app_last_o, 0);
      end
      prev_early = app_early_v_o;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pk;
    int  n;
    int  nb;
    int  t;
    bit  el;
    int  ca;
    nreset     = 1'b0;
    s_valid_i  = 1'b0;
    s_data_i   = '0;
    s_keep_i   = '0;
    s_last_i   = 1'b0;
    s_cancel_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready_o, 1);
    check("rst_early_v", app_early_v_o, 0);
    check("rst_pkt_len", 32'(app_pkt_len_o), 0);
    check("rst_data", 32'(app_data_o), 0);
    check("rst_last", app_last_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_cancel", app_cancel_o, 0);
    check("rst_cs", 32'(app_cs_o), 0);
    @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 19 bytes, grant after 3 cycles
    req_wait = 3;
    send_pkt(mk_pkt(19), 1'b0, -1);
    wait_done();

    // 16 bytes closed by an empty last beat
    req_wait = 1;
    send_pkt(mk_pkt(16), 1'b1, -1);
    wait_done();

    // Cancel on beat 3 of 10, then a clean packet
    send_pkt(mk_pkt(20), 1'b0, 3);
    wait_done();
    send_pkt(mk_pkt(20), 1'b0, -1);
    wait_done();

    // Oversize, exact maximum, zero length
    req_wait = 0;
    send_pkt(mk_pkt(1480), 1'b0, -1);
    wait_done();
    send_pkt(mk_pkt(MAX_PKT_LEN), 1'b0, -1);
    wait_done();
    send_pkt(mk_pkt(0), 1'b0, -1);
    wait_done();

    // Back-to-back 2-byte packets, head held 5 cycles
    req_wait = 5;
    send_pkt(mk_pkt(2), 1'b0, -1);
    send_pkt(mk_pkt(2), 1'b0, -1);
    wait_done();

    // Reset in the middle of the output stream
    req_wait = 1;
    send_pkt(mk_pkt(20), 1'b0, -1);
    t = 0;
    while (app_early_v_o && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_send", app_early_v_o, 0);
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    nreset = 1'b0;
    #1;
    check("midrst_data", 32'(app_data_o), 0);
    check("midrst_len", 32'(app_len_o), 0);
    check("midrst_last", app_last_o, 0);
    check("midrst_pkt_len", 32'(app_pkt_len_o), 0);
    check("midrst_lbn", app_last_block_next_o, 0);
    check("midrst_drop", drop_o, 0);
    check("midrst_s_ready", s_ready_o, 1);
    exp_out.delete();
    exp_beats.delete();
    @(negedge clk);
    nreset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("postrst_s_ready", s_ready_o, 1);
    send_pkt(mk_pkt(11), 1'b0, -1);
    wait_done();

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      n  = $urandom_range(0, 40);
      el = (n % KEEP_W == 0) && ($urandom_range(1) == 1);
      nb = el ? n / KEEP_W + 1 : ((n == 0) ? 1 : (n + KEEP_W - 1) / KEEP_W);
      ca = -1;
      if (nb > 1 && $urandom_range(7) == 0) ca = $urandom_range(1, nb - 1);
      req_wait = $urandom_range(0, 4);
      send_pkt(mk_pkt(n), el, ca);
      if ($urandom_range(1) == 0) wait_done();
    end
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
